router_rx_port: RTL and testbench

Per-port receive engine on the downstream side of the 1x3 router, one instance per output port. It watches `vld_out`, drives `read_enb`, and reassembles each packet from the router FIFO: header, then payload, then parity. Payload goes out on a ready/valid byte stream; the block checks address and parity and reports per-packet status pulses plus a packet counter.

---
 rtl/router_pkg.sv | 17 +
 rtl/rx_skid_buf.sv | 56 +++++
 rtl/router_rx_port.sv | 157 +++++++++++++++
 tb/tb_router_rx_port.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and header field layout for the router receive path.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PLD,
    PAR,
    DONE
  } rx_state_t;

  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int ADDR_W  = 2;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

endpackage

// File: rtl/rx_skid_buf.sv
// Two-entry {last, data} ready/valid buffer; entry 0 is always the head.
module rx_skid_buf (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [8:0] push_data,
  input  logic       pop,
  input  logic       force_last,
  output logic [8:0] head,
  output logic [1:0] occ
);

  logic [8:0] ent0;
  logic [8:0] ent1;
  logic       pop_v;

  assign pop_v = pop && (occ != 2'd0);
  // A lone head byte gets last immediately so an abort never lets it leave unmarked.
  assign head  = {ent0[8] | (force_last && (occ == 2'd1)), ent0[7:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= '0;
    end else begin
      case ({push, pop_v})
        2'b10: begin
          if (occ == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
      // Mark whichever entry is the tail after this cycle's pop.
      if (force_last && !push) begin
        if (occ == 2'd2 && pop_v)       ent0[8] <= 1'b1;
        else if (occ == 2'd2)           ent1[8] <= 1'b1;
        else if (occ == 2'd1 && !pop_v) ent0[8] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_rx_port.sv
// Per-port receive engine: pops header/payload/parity from the router FIFO,
// streams payload through a skid buffer and reports per-packet status.
module router_rx_port
  import router_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PORT_ID = '0,
  parameter int unsigned       TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  output logic        read_enb,
  input  logic        pld_ready,
  output logic        pld_valid,
  output logic [7:0]  pld_data,
  output logic        pld_last,
  output logic        pkt_done,
  output logic        parity_err,
  output logic        addr_err,
  output logic        trunc_err,
  output logic [15:0] pkt_count
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  rx_state_t        state, state_nxt;
  logic             rd_q;
  logic             rd_req;
  logic [LEN_W-1:0] len_q, issued, received;
  logic [7:0]       parity;
  logic             addr_bad, par_bad, trunc, par_sent;
  logic [TW-1:0]    to_cnt;
  logic             to_run, timeout_hit;
  logic             pop, push, pld_room;
  logic [2:0]       fill;
  logic [8:0]       head;
  logic [1:0]       occ;

  assign pop       = pld_valid && pld_ready;
  assign push      = (state == PLD) && rd_q;
  assign pld_valid = (occ != 2'd0);
  assign pld_data  = head[7:0];
  assign pld_last  = head[8];

  // Room is judged against occupancy after this cycle's push and pop.
  assign fill     = {1'b0, occ} + {2'b0, rd_q};
  assign pld_room = fill < (3'd2 + {2'b0, pop});

  assign to_run      = ((state == HDR) || (state == PLD) || (state == PAR)) && !vld_out && !rd_q;
  assign timeout_hit = to_run && (to_cnt == TW'(TIMEOUT - 1));
  assign read_enb    = rd_req && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    case (state)
      IDLE: begin
        if (vld_out) begin
          rd_req    = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR:  state_nxt = (data_out[LEN_MSB:LEN_LSB] == '0) ? PAR : PLD;
      PLD: begin
        rd_req = vld_out && (len_q > issued) && pld_room;
        if (issued == len_q) state_nxt = PAR;
      end
      PAR: begin
        rd_req = vld_out && !par_sent;
        if (rd_q) state_nxt = DONE;
      end
      DONE: if (occ == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = DONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q       <= 1'b0;
      len_q      <= '0;
      issued     <= '0;
      received   <= '0;
      parity     <= '0;
      addr_bad   <= 1'b0;
      par_bad    <= 1'b0;
      trunc      <= 1'b0;
      par_sent   <= 1'b0;
      to_cnt     <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      trunc_err  <= 1'b0;
      pkt_count  <= '0;
    end else begin
      rd_q       <= read_enb;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      trunc_err  <= 1'b0;
      if (read_enb || (state == IDLE)) to_cnt <= '0;
      else if (to_run)                 to_cnt <= to_cnt + TW'(1);
      case (state)
        HDR: begin
          len_q    <= data_out[LEN_MSB:LEN_LSB];
          issued   <= '0;
          received <= '0;
          parity   <= data_out;
          addr_bad <= (data_out[ADDR_W-1:0] != PORT_ID);
          par_bad  <= 1'b0;
          trunc    <= 1'b0;
          par_sent <= 1'b0;
        end
        PLD: begin
          if (read_enb) issued <= issued + LEN_W'(1);
          if (rd_q) begin
            parity   <= parity ^ data_out;
            received <= received + LEN_W'(1);
          end
        end
        PAR: begin
          if (read_enb) par_sent <= 1'b1;
          if (rd_q)     par_bad  <= (data_out != parity);
        end
        DONE: begin
          if (occ == 2'd0) begin
            pkt_done   <= 1'b1;
            parity_err <= par_bad;
            addr_err   <= addr_bad;
            trunc_err  <= trunc;
            pkt_count  <= pkt_count + 16'd1;
          end
        end
        default: ;
      endcase
      if (timeout_hit) trunc <= 1'b1;
    end
  end

  rx_skid_buf u_skid (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_data  ({(received + LEN_W'(1)) == len_q, data_out}),
    .pop        (pop),
    .force_last (timeout_hit),
    .head       (head),
    .occ        (occ)
  );

endmodule

// File: tb/tb_router_rx_port.sv
// Directed scoreboard bench for router_rx_port with a behavioural router FIFO.
module tb_router_rx_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        vld_out;
  logic [7:0]  data_out;
  logic        read_enb;
  logic        pld_ready;
  logic        pld_valid;
  logic [7:0]  pld_data;
  logic        pld_last;
  logic        pkt_done;
  logic        parity_err;
  logic        addr_err;
  logic        trunc_err;
  logic [15:0] pkt_count;

  always #5 clock = ~clock;

  router_rx_port #(.PORT_ID(2'd0), .TIMEOUT(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .read_enb   (read_enb),
    .pld_ready  (pld_ready),
    .pld_valid  (pld_valid),
    .pld_data   (pld_data),
    .pld_last   (pld_last),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .trunc_err  (trunc_err),
    .pkt_count  (pkt_count)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          par_cyc  = 0;
  int          done_cnt = 0;
  bit          lat_chk  = 1'b0;
  bit          hold_v   = 1'b0;
  logic [8:0]  hold_val;
  logic [15:0] exp_count = '0;
  logic [7:0]  fifo[$];
  bit          fifo_par[$];
  logic [8:0]  exp_pld[$];
  logic [2:0]  exp_st[$];
  logic [7:0]  pb[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] hdr, input int n, input logic [7:0] par_xor);
    logic [7:0] p;
    p = hdr;
    fifo.push_back(hdr);
    fifo_par.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      fifo.push_back(pb[i]);
      fifo_par.push_back(1'b0);
      exp_pld.push_back({i == n - 1, pb[i]});
      p = p ^ pb[i];
    end
    fifo.push_back(p ^ par_xor);
    fifo_par.push_back(1'b1);
    exp_st.push_back({par_xor != 8'h00, hdr[1:0] != 2'd0, 1'b0});
    vld_out = 1'b1;
  endtask

  task automatic tick();
    bit rd;
    @(negedge clock);
    cyc++;
    if (read_enb) check("read_enb_without_vld", {31'd0, vld_out}, 32'd1);
    if (hold_v) check("payload_hold", {pld_valid, pld_last, pld_data}, {1'b1, hold_val});
    if (pld_valid && pld_ready) begin
      if (exp_pld.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL pld_extra observed=%0h expected=none", {pld_last, pld_data});
      end else begin
        check("pld_byte", {pld_last, pld_data}, exp_pld.pop_front());
      end
    end
    hold_v   = pld_valid && !pld_ready;
    hold_val = {pld_last, pld_data};
    if (pkt_done) begin
      done_cnt++;
      exp_count = exp_count + 16'd1;
      check("pkt_count", pkt_count, exp_count);
      if (exp_st.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL status_extra observed=%0h expected=none", {parity_err, addr_err, trunc_err});
      end else begin
        check("status", {parity_err, addr_err, trunc_err}, exp_st.pop_front());
      end
      if (lat_chk) check("done_latency", cyc - par_cyc, 2);
    end else begin
      check("err_idle", {parity_err, addr_err, trunc_err}, 3'b000);
    end
    rd = read_enb;
    @(posedge clock);
    #1;
    if (rd && fifo.size() != 0) begin
      data_out = fifo.pop_front();
      if (fifo_par.pop_front()) par_cyc = cyc + 1;
    end
    vld_out = (fifo.size() != 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check(tag, done_cnt - start, 1);
    check("drained", exp_pld.size(), 0);
  endtask

  initial begin
    reset     = 1'b1;
    vld_out   = 1'b0;
    data_out  = 8'h00;
    pld_ready = 1'b1;
    #1;
    check("rst_read_enb", {31'd0, read_enb}, 0);
    check("rst_pld", {pld_valid, pld_last, pld_data}, 10'h000);
    check("rst_status", {pkt_done, parity_err, addr_err, trunc_err}, 4'h0);
    check("rst_count", pkt_count, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Clean packet, streaming, with pkt_done latency check.
    pb = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    lat_chk = 1'b1;
    send(8'h0C, 3, 8'h00);
    wait_done("done_clean", 40);
    lat_chk = 1'b0;

    // Bad parity byte 8'hFF.
    send(8'h0C, 3, 8'hF3);
    wait_done("done_parity", 40);

    // Address mismatch, still drained.
    pb[0] = 8'h5A;
    send(8'h05, 1, 8'h00);
    wait_done("done_addr", 40);

    // Zero-length packet.
    send(8'h00, 0, 8'h00);
    wait_done("done_len0", 40);

    // Sink stall mid-payload.
    pb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00};
    send(8'h10, 4, 8'h00);
    for (int n = 0; n < 20 && exp_pld.size() > 3; n++) tick();
    check("stall_first_byte", exp_pld.size(), 3);
    pld_ready = 1'b0;
    repeat (5) tick();
    check("stall_read_stopped", {31'd0, read_enb}, 0);
    check("stall_vld_pending", {31'd0, vld_out}, 1);
    pld_ready = 1'b1;
    wait_done("done_stall", 40);

    // Truncation: only 2 of 5 payload bytes ever arrive.
    pld_ready = 1'b0;
    fifo.push_back(8'h14); fifo_par.push_back(1'b0);
    fifo.push_back(8'h31); fifo_par.push_back(1'b0);
    fifo.push_back(8'h32); fifo_par.push_back(1'b0);
    exp_pld.push_back({1'b0, 8'h31});
    exp_pld.push_back({1'b1, 8'h32});
    exp_st.push_back(3'b001);
    vld_out = 1'b1;
    repeat (75) tick();
    check("trunc_no_early_done", done_cnt, 5);
    pld_ready = 1'b1;
    wait_done("done_trunc", 20);

    // Next packet after abort is received normally.
    pb = '{8'h66, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(8'h08, 2, 8'h00);
    wait_done("done_after_trunc", 40);

    // Reset in the middle of a payload.
    pb = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h00, 8'h00, 8'h00};
    send(8'h14, 5, 8'h00);
    for (int n = 0; n < 20 && exp_pld.size() > 4; n++) tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_read_enb", {31'd0, read_enb}, 0);
    check("midrst_pld", {pld_valid, pld_last, pld_data}, 10'h000);
    check("midrst_status", {pkt_done, parity_err, addr_err, trunc_err}, 4'h0);
    check("midrst_count", pkt_count, 0);
    fifo.delete();
    fifo_par.delete();
    exp_pld.delete();
    exp_st.delete();
    exp_count = '0;
    hold_v    = 1'b0;
    vld_out   = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    pb = '{8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(8'h08, 2, 8'h00);
    wait_done("done_after_reset", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
